adc_ddr_capture_gen: RTL and testbench

//  Parametrised DDR ADC capture engine for the linear-sensor readout path.

---
 rtl/adc_ddr_capture_gen.sv | 211 +++++++++++++++++++++
 tb/tb_adc_ddr_capture_gen.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_ddr_capture_gen.sv
// DDR ADC capture engine: forwards clk to the ADC, waits out the pipeline latency,
// then packs PIX_NUM {rise,fall} samples into RAM words with a zero-padded tail.
module adc_ddr_capture_gen #(
  parameter int ADC_BITS  = 8,
  parameter int PIX_NUM   = 512,
  parameter int PIPE_DLY  = 4,
  parameter int SPW       = 2,
  parameter int RAM_AW    = 10,
  parameter int BYTE_ADDR = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      adc_clk_o,
  input  logic [ADC_BITS-1:0]       adc_data_in,
  output logic                      adc_oeb,
  input  logic                      adc_start_in,
  input  logic                      abort_in,
  input  logic [RAM_AW-1:0]         base_addr_in,
  output logic                      busy_o,
  output logic                      adc_done_out,
  output logic                      aborted_o,
  output logic                      overrun_o,
  output logic [15:0]               frame_cnt_o,
  output logic [RAM_AW-1:0]         ram_addr_o,
  output logic [SPW*2*ADC_BITS-1:0] ram_data_o,
  output logic                      ram_wr_o
);

  localparam int SW     = 2 * ADC_BITS;
  localparam int WW     = SPW * SW;
  localparam int LW     = (SPW > 1) ? $clog2(SPW) : 1;
  localparam int STEP_I = (BYTE_ADDR != 0) ? ((WW / 8 > 0) ? WW / 8 : 1) : 1;
  localparam logic [RAM_AW-1:0] STEP = RAM_AW'(STEP_I);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATENCY,
    S_CAPTURE,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          dly_q, dly_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [LW-1:0]       lane_q, lane_d;
  logic [WW-1:0]       pack_q, pack_d;
  logic                full_q, full_d;
  logic [RAM_AW-1:0]   addr_q, addr_d;
  logic                wr_q, wr_d;
  logic [WW-1:0]       wdata_q, wdata_d;
  logic [RAM_AW-1:0]   waddr_q, waddr_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;
  logic                overrun_q, overrun_d;
  logic [15:0]         fcnt_q, fcnt_d;

  logic [ADC_BITS-1:0] r_q, f_q, f_sync_q;
  logic [SW-1:0]       sample;
  logic                last_sample;
  logic                abort_take;

  // Falling-edge half is caught on negedge, then moved back onto the posedge grid.
  always_ff @(negedge clk) begin
    f_q <= adc_data_in;
  end

  always_ff @(posedge clk) begin
    r_q      <= adc_data_in;
    f_sync_q <= f_q;
  end

  assign sample      = {r_q, f_sync_q};
  assign last_sample = (cnt_q == 16'(PIX_NUM - 1));
  assign abort_take  = abort_in && ((state_q == S_LATENCY) || (state_q == S_CAPTURE) ||
                                    (state_q == S_FLUSH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      dly_q     <= '0;
      cnt_q     <= '0;
      lane_q    <= '0;
      pack_q    <= '0;
      full_q    <= 1'b0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      waddr_q   <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      overrun_q <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      cnt_q     <= cnt_d;
      lane_q    <= lane_d;
      pack_q    <= pack_d;
      full_q    <= full_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      waddr_q   <= waddr_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      overrun_q <= overrun_d;
      fcnt_q    <= fcnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    cnt_d     = cnt_q;
    lane_d    = lane_q;
    pack_d    = pack_q;
    full_d    = 1'b0;
    addr_d    = addr_q;
    wr_d      = 1'b0;
    wdata_d   = wdata_q;
    waddr_d   = waddr_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    overrun_d = overrun_q;
    fcnt_d    = fcnt_q;

    // A completed (or final partial) word is written one cycle after it fills.
    if (full_q) begin
      wr_d    = 1'b1;
      wdata_d = pack_q;
      waddr_d = addr_q;
      addr_d  = addr_q + STEP;
    end

    if (adc_start_in && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (adc_start_in) begin
          state_d = S_LATENCY;
          addr_d  = base_addr_in;
          dly_d   = '0;
          cnt_d   = '0;
          lane_d  = '0;
          pack_d  = '0;
        end
      end
      S_LATENCY: begin
        if (dly_q == 4'(PIPE_DLY - 1)) begin
          state_d = S_CAPTURE;
        end else begin
          dly_d = dly_q + 4'd1;
        end
      end
      S_CAPTURE: begin
        // Lane 0 starts a fresh word, so a short tail leaves its upper lanes zero.
        if (lane_q == '0) begin
          pack_d = '0;
        end
        for (int i = 0; i < SPW; i++) begin
          if (lane_q == LW'(i)) begin
            pack_d[i*SW +: SW] = sample;
          end
        end
        full_d = (lane_q == LW'(SPW - 1)) || last_sample;
        lane_d = (lane_q == LW'(SPW - 1)) ? '0 : lane_q + LW'(1);
        cnt_d  = cnt_q + 16'd1;
        if (last_sample) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        fcnt_d  = fcnt_q + 16'd1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The write already on the bus finishes; anything still pending is dropped.
    if (abort_take) begin
      state_d   = S_IDLE;
      aborted_d = 1'b1;
      full_d    = 1'b0;
      wr_d      = 1'b0;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      waddr_d   = waddr_q;
    end
  end

  assign adc_clk_o    = clk;
  assign adc_oeb      = 1'b0;
  assign busy_o       = (state_q != S_IDLE);
  assign adc_done_out = done_q;
  assign aborted_o    = aborted_q;
  assign overrun_o    = overrun_q;
  assign frame_cnt_o  = fcnt_q;
  assign ram_addr_o   = waddr_q;
  assign ram_data_o   = wdata_q;
  assign ram_wr_o     = wr_q;

endmodule

// File: tb/tb_adc_ddr_capture_gen.sv
// Directed bench for adc_ddr_capture_gen: 11-sample frames, 4 samples per word,
// byte addressing (step 8); ramp data makes sample k = {2k+1, 2k}.
module tb_adc_ddr_capture_gen;

  localparam int PIPE_DLY = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        adc_clk_o;
  logic [7:0]  adc_data = 8'h00;
  logic        adc_oeb;
  logic        adc_start = 1'b0;
  logic        abort = 1'b0;
  logic [9:0]  base_addr = 10'h000;
  logic        busy_o, adc_done_out, aborted_o, overrun_o, ram_wr_o;
  logic [15:0] frame_cnt_o;
  logic [9:0]  ram_addr_o;
  logic [63:0] ram_data_o;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int half_cnt = 0;
  int ramp_base = 0;
  int s_cyc = 0;

  logic [9:0]  wr_addr_q[$];
  logic [63:0] wr_data_q[$];
  int          wr_cyc_q[$];
  int          done_cyc_q[$];
  int          abt_cyc_q[$];

  logic [63:0] exp_word [3] = '{64'h0706050403020100, 64'h0f0e0d0c0b0a0908, 64'h0000151413121110};
  int          exp_wcyc [3] = '{10, 14, 17};

  adc_ddr_capture_gen #(
    .ADC_BITS(8), .PIX_NUM(11), .PIPE_DLY(PIPE_DLY), .SPW(4), .RAM_AW(10), .BYTE_ADDR(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .adc_clk_o(adc_clk_o), .adc_data_in(adc_data), .adc_oeb(adc_oeb),
    .adc_start_in(adc_start), .abort_in(abort), .base_addr_in(base_addr), .busy_o(busy_o),
    .adc_done_out(adc_done_out), .aborted_o(aborted_o), .overrun_o(overrun_o),
    .frame_cnt_o(frame_cnt_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_wr_o(ram_wr_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // DDR source: a new byte for every clock edge, driven 2 time units after each edge.
  always @(clk) begin
    #2;
    adc_data = 8'(half_cnt - ramp_base);
    half_cnt = half_cnt + 1;
  end

  always @(negedge clk) begin
    if (ram_wr_o === 1'b1) begin
      wr_addr_q.push_back(ram_addr_o);
      wr_data_q.push_back(ram_data_o);
      wr_cyc_q.push_back(cyc);
    end
    if (adc_done_out === 1'b1) done_cyc_q.push_back(cyc);
    if (aborted_o === 1'b1) abt_cyc_q.push_back(cyc);
  end

  // Start pulse in cycle 0; aligns the ramp so the first captured sample is {01,00}.
  task automatic start_frame(input logic [9:0] base, input logic with_abort);
    @(posedge clk); #1;
    ramp_base = half_cnt + 2 * PIPE_DLY;
    base_addr = base;
    adc_start = 1'b1;
    abort     = with_abort;
    s_cyc     = cyc;
    @(posedge clk); #1;
    adc_start = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    vectors++; if (ram_wr_o !== 1'b0) begin miscompares++; $display("FAIL rst_wr: got %b want 0", ram_wr_o); end
    vectors++; if (ram_addr_o !== 10'h000) begin miscompares++; $display("FAIL rst_addr: got %h want 000", ram_addr_o); end
    vectors++; if (ram_data_o !== 64'h0) begin miscompares++; $display("FAIL rst_data: got %h want 0", ram_data_o); end
    vectors++; if (frame_cnt_o !== 16'h0) begin miscompares++; $display("FAIL rst_fcnt: got %h want 0", frame_cnt_o); end
    vectors++; if ({adc_done_out, aborted_o, overrun_o} !== 3'b000) begin
      miscompares++; $display("FAIL rst_flags: done/abt/ovr got %b want 000", {adc_done_out, aborted_o, overrun_o});
    end
    vectors++; if (adc_oeb !== 1'b0) begin miscompares++; $display("FAIL rst_oeb: got %b want 0", adc_oeb); end
    vectors++; if (adc_clk_o !== 1'b1) begin miscompares++; $display("FAIL adc_clk_hi: got %b want 1", adc_clk_o); end
    @(negedge clk); #1;
    vectors++; if (adc_clk_o !== 1'b0) begin miscompares++; $display("FAIL adc_clk_lo: got %b want 0", adc_clk_o); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL post_rst_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_frame(input logic [9:0] base, input logic [15:0] exp_fc, input logic with_abort);
    int w0, d0, a0;
    logic [9:0] ea;
    w0 = wr_addr_q.size();
    d0 = done_cyc_q.size();
    a0 = abt_cyc_q.size();
    start_frame(base, with_abort);
    vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL frame_busy: got %b want 1", busy_o); end
    repeat (22) @(posedge clk);
    #1;
    vectors++; if (wr_addr_q.size() - w0 != 3) begin
      miscompares++; $display("FAIL frame_nwr: got %0d writes want 3", wr_addr_q.size() - w0);
    end
    for (int i = 0; i < 3; i++) begin
      if (w0 + i < wr_addr_q.size()) begin
        ea = base + 10'(8 * i);
        vectors++; if (wr_addr_q[w0+i] !== ea) begin
          miscompares++; $display("FAIL frame_addr[%0d]: got %h want %h", i, wr_addr_q[w0+i], ea);
        end
        vectors++; if (wr_data_q[w0+i] !== exp_word[i]) begin
          miscompares++; $display("FAIL frame_data[%0d]: got %h want %h", i, wr_data_q[w0+i], exp_word[i]);
        end
        vectors++; if (wr_cyc_q[w0+i] != s_cyc + exp_wcyc[i]) begin
          miscompares++; $display("FAIL frame_wcyc[%0d]: got +%0d want +%0d", i, wr_cyc_q[w0+i] - s_cyc, exp_wcyc[i]);
        end
      end
    end
    vectors++; if (done_cyc_q.size() - d0 != 1) begin
      miscompares++; $display("FAIL frame_ndone: got %0d want 1", done_cyc_q.size() - d0);
    end else begin
      vectors++; if (done_cyc_q[d0] != s_cyc + 18) begin
        miscompares++; $display("FAIL frame_done_cyc: got +%0d want +18", done_cyc_q[d0] - s_cyc);
      end
    end
    vectors++; if (abt_cyc_q.size() != a0) begin
      miscompares++; $display("FAIL frame_abt: got %0d pulses want 0", abt_cyc_q.size() - a0);
    end
    vectors++; if (frame_cnt_o !== exp_fc) begin miscompares++; $display("FAIL frame_fcnt: got %0d want %0d", frame_cnt_o, exp_fc); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL frame_idle: got %b want 0", busy_o); end
  endtask

  task automatic test_wrap;
    int a0;
    a0 = abt_cyc_q.size();
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    vectors++; if (aborted_o !== 1'b0) begin miscompares++; $display("FAIL idle_abort: got %b want 0", aborted_o); end
    vectors++; if (abt_cyc_q.size() != a0) begin miscompares++; $display("FAIL idle_abort_q: got %0d want 0", abt_cyc_q.size() - a0); end
    // start and abort together in IDLE: start wins; addresses wrap past 0x3FF
    test_frame(10'h3F0, 16'd2, 1'b1);
  endtask

  task automatic test_abort;
    int w0, d0, a0;
    w0 = wr_addr_q.size();
    d0 = done_cyc_q.size();
    a0 = abt_cyc_q.size();
    start_frame(10'h040, 1'b0);
    repeat (13) @(posedge clk);
    #1;
    vectors++; if (ram_wr_o !== 1'b1) begin miscompares++; $display("FAIL abt_wr_same_cycle: got %b want 1", ram_wr_o); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    vectors++; if (aborted_o !== 1'b1) begin miscompares++; $display("FAIL abt_pulse: got %b want 1", aborted_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL abt_busy: got %b want 0", busy_o); end
    repeat (10) @(posedge clk);
    #1;
    vectors++; if (wr_addr_q.size() - w0 != 2) begin
      miscompares++; $display("FAIL abt_nwr: got %0d writes want 2", wr_addr_q.size() - w0);
    end else begin
      vectors++; if (wr_addr_q[w0+1] !== 10'h048) begin miscompares++; $display("FAIL abt_addr1: got %h want 048", wr_addr_q[w0+1]); end
      vectors++; if (wr_data_q[w0+1] !== exp_word[1]) begin
        miscompares++; $display("FAIL abt_data1: got %h want %h", wr_data_q[w0+1], exp_word[1]);
      end
    end
    vectors++; if (abt_cyc_q.size() - a0 != 1) begin
      miscompares++; $display("FAIL abt_npulse: got %0d want 1", abt_cyc_q.size() - a0);
    end else begin
      vectors++; if (abt_cyc_q[a0] != s_cyc + 15) begin
        miscompares++; $display("FAIL abt_cyc: got +%0d want +15", abt_cyc_q[a0] - s_cyc);
      end
    end
    vectors++; if (done_cyc_q.size() != d0) begin miscompares++; $display("FAIL abt_done: got %0d want 0", done_cyc_q.size() - d0); end
    vectors++; if (frame_cnt_o !== 16'd2) begin miscompares++; $display("FAIL abt_fcnt: got %0d want 2", frame_cnt_o); end
    vectors++; if (overrun_o !== 1'b0) begin miscompares++; $display("FAIL abt_ovr: got %b want 0", overrun_o); end
    test_frame(10'h040, 16'd3, 1'b0);
  endtask

  task automatic test_overrun;
    int w0, d0;
    w0 = wr_addr_q.size();
    d0 = done_cyc_q.size();
    start_frame(10'h200, 1'b0);
    @(posedge clk); #1;
    adc_start = 1'b1;
    base_addr = 10'h300;
    @(posedge clk); #1;
    adc_start = 1'b0;
    vectors++; if (overrun_o !== 1'b1) begin miscompares++; $display("FAIL ovr_set: got %b want 1", overrun_o); end
    repeat (20) @(posedge clk);
    #1;
    vectors++; if (wr_addr_q.size() - w0 != 3) begin
      miscompares++; $display("FAIL ovr_nwr: got %0d writes want 3", wr_addr_q.size() - w0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++; if (wr_addr_q[w0+i] !== 10'(10'h200 + 8 * i)) begin
          miscompares++; $display("FAIL ovr_addr[%0d]: got %h want %h", i, wr_addr_q[w0+i], 10'(10'h200 + 8 * i));
        end
        vectors++; if (wr_data_q[w0+i] !== exp_word[i]) begin
          miscompares++; $display("FAIL ovr_data[%0d]: got %h want %h", i, wr_data_q[w0+i], exp_word[i]);
        end
      end
    end
    vectors++; if (done_cyc_q.size() - d0 != 1) begin miscompares++; $display("FAIL ovr_ndone: got %0d want 1", done_cyc_q.size() - d0); end
    vectors++; if (frame_cnt_o !== 16'd4) begin miscompares++; $display("FAIL ovr_fcnt: got %0d want 4", frame_cnt_o); end
    vectors++; if (overrun_o !== 1'b1) begin miscompares++; $display("FAIL ovr_sticky: got %b want 1", overrun_o); end
  endtask

  task automatic test_reset_mid;
    int d0;
    d0 = done_cyc_q.size();
    start_frame(10'h080, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    vectors++; if ({busy_o, ram_wr_o, adc_done_out, aborted_o, overrun_o} !== 5'b0) begin
      miscompares++; $display("FAIL mid_rst_flags: busy/wr/done/abt/ovr got %b want 00000",
                              {busy_o, ram_wr_o, adc_done_out, aborted_o, overrun_o});
    end
    vectors++; if (frame_cnt_o !== 16'd0) begin miscompares++; $display("FAIL mid_rst_fcnt: got %0d want 0", frame_cnt_o); end
    vectors++; if ({ram_addr_o, ram_data_o} !== 74'h0) begin
      miscompares++; $display("FAIL mid_rst_bus: addr %h data %h want 0", ram_addr_o, ram_data_o);
    end
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    vectors++; if (wr_cyc_q.size() > 0 && wr_cyc_q[wr_cyc_q.size()-1] >= s_cyc + 12) begin
      miscompares++; $display("FAIL mid_rst_wr: write at +%0d want none after +11", wr_cyc_q[wr_cyc_q.size()-1] - s_cyc);
    end
    vectors++; if (done_cyc_q.size() != d0) begin miscompares++; $display("FAIL mid_rst_done: got %0d want 0", done_cyc_q.size() - d0); end
    test_frame(10'h080, 16'd1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_frame(10'h100, 16'd1, 1'b0);
    test_wrap();
    test_abort();
    test_overrun();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
